// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage RISC-V core.
//
// Produces the per-stage stall/flush controls for the IF/ID, ID/EX, EX/MEM
// and MEM/WB pipeline registers. It also sequences the multi-cycle
// data-memory handshake for the instruction held in EX/MEM, detects
// load-use hazards between ID and EX, and squashes younger instructions
// when a taken branch is resolved in MEM.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   id_rs1/rs2_addr_i, _used_i    source operands of the instruction in ID
//   ex_mem_read_i, ex_write_addr_i  load flag and destination of EX instruction
//   mem_read_i, mem_write_i       EX/MEM holds a load / a store
//   mem_branch_i, branch_ce_i     EX/MEM holds a branch / its condition is true
//   dmem_ack_i, dmem_req_o        data-memory handshake
//   stall_*_o, flush_*_o, bubble_wb_o  pipeline register controls
//   mem_err_o                     sticky memory-timeout error (exit by reset)
//   stall_cnt_o, flush_cnt_o      performance counters
//
// Optional feature: define PIPE_CTRL_PERF_EN to build saturating
// stall/flush counters. Without it, both counter ports are tied to 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | no memory wait pending; hazards and branches are serviced
// MEM_WAIT | EX/MEM access outstanding; the pipe is frozen until ack
// MEM_ERR  | the access timed out; the pipe stays frozen until reset
module pipe_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_write_addr_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_branch_i,
  input  logic                  branch_ce_i,
  input  logic                  dmem_ack_i,
  output logic                  dmem_req_o,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  stall_ex_o,
  output logic                  stall_mem_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic                  flush_mem_o,
  output logic                  bubble_wb_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       access;
  logic       taken;
  logic       lu_hazard;
  logic       mem_hold;

  assign access = mem_read_i | mem_write_i;
  assign taken  = mem_branch_i & branch_ce_i;

  assign lu_hazard = ex_mem_read_i && (ex_write_addr_i != '0) &&
                     ((id_rs1_used_i && (id_rs1_addr_i == ex_write_addr_i)) ||
                      (id_rs2_used_i && (id_rs2_addr_i == ex_write_addr_i)));

  // wait_cnt holds the number of stalled cycles already spent on the
  // current access. The first stall happens in RUN, so MEM_WAIT starts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (access && !dmem_ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT) begin
            state     <= MEM_ERR;
            mem_err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        MEM_ERR: ;
        default: state <= RUN;
      endcase
    end
  end

  // Controls are combinational so that a hazard is answered in the cycle
  // it appears. They are forced low while reset is asserted, which also
  // drops dmem_req_o immediately if reset hits in the middle of a wait.
  always_comb begin
    dmem_req_o  = 1'b0;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    flush_mem_o = 1'b0;
    bubble_wb_o = 1'b0;
    mem_hold    = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          dmem_req_o = access;
          mem_hold   = access & ~dmem_ack_i;
        end
        MEM_WAIT: begin
          dmem_req_o = 1'b1;
          mem_hold   = ~dmem_ack_i;
        end
        default: mem_hold = 1'b1;
      endcase

      // In the ack cycle the pipe is released, so a branch that shares
      // EX/MEM with the access gets its flush in that cycle.
      if (mem_hold) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
        bubble_wb_o = 1'b1;
      end else if (taken) begin
        flush_id_o  = 1'b1;
        flush_ex_o  = 1'b1;
        flush_mem_o = 1'b1;
      end else if (lu_hazard) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // flush_id_o is only ever raised by a taken branch, so it marks the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_if_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_id_o && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by randomized
// stimulus, every cycle compared against a behavioural model of the
// controller's rules (outstanding access age, sticky error, priorities).
module tb_pipe_ctrl;
  localparam int AW = 5;
  localparam int TO = 15;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, ex_write_addr_i;
  logic          id_rs1_used_i, id_rs2_used_i, ex_mem_read_i;
  logic          mem_read_i, mem_write_i, mem_branch_i, branch_ce_i, dmem_ack_i;
  logic          dmem_req_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic          flush_id_o, flush_ex_o, flush_mem_o, bubble_wb_o, mem_err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  pipe_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_write_addr_i(ex_write_addr_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_branch_i(mem_branch_i), .branch_ce_i(branch_ce_i),
    .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
    .flush_mem_o(flush_mem_o), .bubble_wb_o(bubble_wb_o),
    .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: how many stalled cycles the current access has
  // already spent, whether the timeout error has been raised, and the
  // event totals for the counters.
  int     m_age;
  bit     m_err;
  longint m_stall_cnt, m_flush_cnt;
  localparam longint CNT_MAX = (longint'(1) << CW) - 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {dmem_req_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
            flush_id_o, flush_ex_o, flush_mem_o, bubble_wb_o, mem_err_o};
  endfunction

  task automatic idle_inputs();
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_write_addr_i = '0;
    id_rs1_used_i = 0; id_rs2_used_i = 0; ex_mem_read_i = 0;
    mem_read_i = 0; mem_write_i = 0; mem_branch_i = 0; branch_ce_i = 0;
    dmem_ack_i = 0;
  endtask

  task automatic rand_inputs(input int ack_pct);
    id_rs1_addr_i   = AW'($urandom_range(0, 3));
    id_rs2_addr_i   = AW'($urandom_range(0, 3));
    ex_write_addr_i = AW'($urandom_range(0, 3));
    id_rs1_used_i   = 1'($urandom_range(0, 1));
    id_rs2_used_i   = 1'($urandom_range(0, 1));
    ex_mem_read_i   = 1'($urandom_range(0, 1));
    mem_read_i      = ($urandom_range(0, 3) == 0);
    mem_write_i     = ($urandom_range(0, 3) == 0);
    mem_branch_i    = 1'($urandom_range(0, 1));
    branch_ce_i     = 1'($urandom_range(0, 1));
    dmem_ack_i      = ($urandom_range(0, 99) < ack_pct);
  endtask

  // Inputs are already applied; evaluate mid-cycle, compare, then clock.
  task automatic step(input string tag);
    bit access, taken, hz, pending, hold;
    bit req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, bub;
    logic [9:0] exp;
    #3;
    access  = mem_read_i | mem_write_i;
    taken   = mem_branch_i & branch_ce_i;
    hz      = ex_mem_read_i && ex_write_addr_i != 0 &&
              ((id_rs1_used_i && id_rs1_addr_i == ex_write_addr_i) ||
               (id_rs2_used_i && id_rs2_addr_i == ex_write_addr_i));
    pending = (m_age > 0);
    {req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, bub} = '0;
    hold = 0;
    if (m_err) begin
      {s_if, s_id, s_ex, s_mem, bub} = '1;
    end else begin
      req  = pending | access;
      hold = req & !dmem_ack_i;
      if (hold)       {s_if, s_id, s_ex, s_mem, bub} = '1;
      else if (taken) {f_id, f_ex, f_mem} = '1;
      else if (hz)    {s_if, s_id, f_ex} = '1;
    end
    exp = {req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, bub, m_err};
    check_eq(tag, 32'(obs_vec()), 32'(exp));
`ifdef PIPE_CTRL_PERF_EN
    check_eq({tag, "_stall_cnt"}, stall_cnt_o, m_stall_cnt[31:0]);
    check_eq({tag, "_flush_cnt"}, flush_cnt_o, m_flush_cnt[31:0]);
`else
    check_eq({tag, "_stall_cnt"}, stall_cnt_o, 32'd0);
    check_eq({tag, "_flush_cnt"}, flush_cnt_o, 32'd0);
`endif
    @(posedge clk);
    if (!m_err) begin
      if (hold) begin
        if (m_age == TO) m_err = 1;
        else m_age++;
      end else begin
        m_age = 0;
      end
    end
    if (s_if && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (f_id && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    #1;
  endtask

  // Asserts reset away from the clock edge and checks the outputs drop
  // immediately, even with a live access on the inputs.
  task automatic do_reset(input string tag);
    rst = 0;
    #1;
    check_eq({tag, "_async"}, 32'(obs_vec()), 32'd0);
    m_age = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    @(posedge clk);
    #1;
    check_eq({tag, "_held"}, 32'(obs_vec()), 32'd0);
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    mem_read_i = 1; ex_mem_read_i = 1; ex_write_addr_i = 5;
    id_rs1_addr_i = 5; id_rs1_used_i = 1;
    @(posedge clk); #1;
    do_reset("reset_init");

    // Load-use on x5, then the load moves on, then the x0 case.
    idle_inputs();
    ex_mem_read_i = 1; ex_write_addr_i = 5; id_rs1_addr_i = 5; id_rs1_used_i = 1;
    step("lu_x5");
    ex_mem_read_i = 0;
    step("lu_clear");
    ex_mem_read_i = 1; ex_write_addr_i = 0; id_rs1_addr_i = 0;
    step("lu_x0");

    // Zero-wait load.
    idle_inputs();
    mem_read_i = 1; dmem_ack_i = 1;
    step("load_zero_wait");
    idle_inputs();
    step("after_zero_wait");

    // Store acknowledged after 3 stalled cycles.
    mem_write_i = 1;
    for (int i = 0; i < 3; i++) step("store_wait");
    dmem_ack_i = 1;
    step("store_ack");
    idle_inputs();
    step("store_done");

    // Load that never completes: timeout into the error state.
    mem_read_i = 1;
    for (int i = 0; i < TO + 4; i++) step("load_timeout");
    check_eq("mem_err_set", 32'(mem_err_o), 32'd1);
    do_reset("reset_from_err");

    // Taken branch together with a load-use condition.
    idle_inputs();
    mem_branch_i = 1; branch_ce_i = 1;
    ex_mem_read_i = 1; ex_write_addr_i = 7; id_rs2_addr_i = 7; id_rs2_used_i = 1;
    step("taken_over_lu");
    mem_branch_i = 0;
    step("lu_after_branch");

    // Access and branch together: stall first, flush in the ack cycle.
    idle_inputs();
    mem_read_i = 1; mem_branch_i = 1; branch_ce_i = 1;
    step("acc_taken_wait");
    dmem_ack_i = 1;
    step("acc_taken_ack");

    // Reset while waiting on memory.
    idle_inputs();
    mem_read_i = 1;
    step("wait_c1");
    step("wait_c2");
    do_reset("reset_mid_wait");
    idle_inputs();
    step("run_after_reset");

    // Randomized traffic with occasional resets; some phases rarely ack
    // so that timeouts are reached.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs((i / 500) % 2 == 0 ? 40 : 5);
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
        do_reset("rand_reset");
      else
        step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
